// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl
// APB-master sequencer that reprograms the PWM advanced timer on timer-event
// boundaries. Register writes {addr,data,last} are queued in a small FIFO;
// each rising edge of the selected timer event releases one group of writes
// (up to and including the entry with last=1) onto a private APB port.
//
// Ports
//   clk, resetn             system clock, async active-low reset
//   en, trig_sel, ev        trigger enable, event select, timer events
//   flush                   pulse: empty FIFO, drop pending trigger, abandon group
//   push_*                  FIFO write port (valid/ready, addr, data, last)
//   level                   FIFO occupancy 0..DEPTH
//   busy                    sequencer not idle
//   underrun, overrun       1-cycle status pulses (registered)
//   err, err_clr            sticky PSLVERR flag and its clear
//   m_*                     APB master port
//
// state  | meaning
// IDLE   | waiting for a trigger (fresh or pending)
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready
// GWAIT  | group not finished but FIFO empty; waiting for the next entry
module pwm_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic [1:0]             trig_sel,
  input  logic [3:0]             ev,
  input  logic                   flush,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [AW-1:0]          push_addr,
  input  logic [DW-1:0]          push_data,
  input  logic                   push_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   underrun,
  output logic                   overrun,
  output logic                   err,
  input  logic                   err_clr,
  output logic                   m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [AW-1:0]          m_paddr,
  output logic [DW-1:0]          m_pwdata,
  input  logic                   m_pready,
  input  logic                   m_pslverr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GWAIT} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic          fifo_last [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic [3:0] ev_q;
  logic       pending, pending_nxt;
  logic       abandon, abandon_nxt;
  logic       cur_last;
  logic       underrun_nxt, overrun_nxt;
  logic       trig, full, fifo_empty, push_fire, pop;

  // A flush in the same cycle drops the trigger outright.
  assign trig       = en & ev[trig_sel] & ~ev_q[trig_sel] & ~flush;
  assign full       = (level == LW'(DEPTH));
  assign fifo_empty = (level == '0);
  assign push_ready = ~full & ~flush;
  assign push_fire  = push_valid & push_ready;

  assign busy      = (state != IDLE);
  assign m_psel    = (state == SETUP) | (state == ACCESS);
  assign m_penable = (state == ACCESS);
  assign m_pwrite  = m_psel;

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    abandon_nxt  = abandon;
    underrun_nxt = 1'b0;
    overrun_nxt  = 1'b0;
    pop          = 1'b0;

    // Triggers seen while a group is running are remembered once.
    if (state != IDLE && trig) begin
      if (pending) overrun_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        abandon_nxt = 1'b0;
        if ((trig | pending) && !flush) begin
          pending_nxt = 1'b0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            underrun_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (flush) abandon_nxt = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (flush) abandon_nxt = 1'b1;
        if (m_pready) begin
          if (flush || abandon || cur_last) begin
            state_nxt   = IDLE;
            abandon_nxt = 1'b0;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            underrun_nxt = 1'b1;
            state_nxt    = GWAIT;
          end
        end
      end
      GWAIT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (flush) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ev_q     <= '0;
      pending  <= 1'b0;
      abandon  <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ev_q     <= ev;
      pending  <= pending_nxt;
      abandon  <= abandon_nxt;
      underrun <= underrun_nxt;
      overrun  <= overrun_nxt;
      if (state == ACCESS && m_pready && m_pslverr) err <= 1'b1;
      else if (err_clr)                             err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push_fire) - LW'(pop);
    end
  end

  // Storage has no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_paddr  <= '0;
      m_pwdata <= '0;
      cur_last <= 1'b0;
    end else if (pop) begin
      m_paddr  <= fifo_addr[rd_ptr];
      m_pwdata <= fifo_data[rd_ptr];
      cur_last <= fifo_last[rd_ptr];
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
module tb_pwm_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [1:0]  trig_sel;
  logic [3:0]  ev;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [11:0] push_addr;
  logic [31:0] push_data;
  logic        push_last;
  logic [3:0]  level;
  logic        busy, underrun, overrun, err, err_clr;
  logic        m_psel, m_penable, m_pwrite;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pready, m_pslverr;

  int n_cmp = 0;
  int n_err = 0;

  int ws = 0;
  int err_at = -1;
  int wr_cnt = 0;
  logic [11:0] log_addr [64];
  logic [31:0] log_data [64];

  pwm_seq_ctrl #(.DEPTH(8), .AW(12), .DW(32)) dut (
    .clk(clk), .resetn(resetn), .en(en), .trig_sel(trig_sel), .ev(ev),
    .flush(flush), .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data), .push_last(push_last),
    .level(level), .busy(busy), .underrun(underrun), .overrun(overrun),
    .err(err), .err_clr(err_clr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  // APB slave: ws wait states per access, logs every completed write.
  initial begin
    int cnt;
    cnt = 0;
    m_pready = 1'b0;
    m_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (m_psel && m_penable) begin
        if (cnt >= ws) begin
          m_pready  = 1'b1;
          m_pslverr = (wr_cnt == err_at);
          log_addr[wr_cnt % 64] = m_paddr;
          log_data[wr_cnt % 64] = m_pwdata;
          wr_cnt++;
          cnt = 0;
        end else begin
          m_pready  = 1'b0;
          m_pslverr = 1'b0;
          cnt++;
        end
      end else begin
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic push(input logic [11:0] a, input logic [31:0] d, input logic l);
    push_valid = 1'b1; push_addr = a; push_data = d; push_last = l;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic pulse_ev(input int b);
    ev[b] = 1'b1;
    @(negedge clk);
    ev[b] = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 1'b1; trig_sel = 2'd0; ev = 4'h0; flush = 1'b0;
    push_valid = 1'b0; push_addr = '0; push_data = '0; push_last = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_psel !== 1'b0 || m_penable !== 1'b0 || m_pwrite !== 1'b0) begin n_err++; $display("FAIL rst_apb_async psel=%b penable=%b pwrite=%b expected 0", m_psel, m_penable, m_pwrite); end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (level !== 4'd0)     begin n_err++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL rst_push_ready got=%b exp=1", push_ready); end
    n_cmp++; if ({err, underrun, overrun} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {err, underrun, overrun}); end
    n_cmp++; if (m_paddr !== 12'h0 || m_pwdata !== 32'h0) begin n_err++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", m_paddr, m_pwdata); end
  endtask

  task automatic test_basic_group();
    bit ok;
    int base;
    base = wr_cnt;
    ws = 0;
    push(12'h00C, 32'h40, 1'b0);
    push(12'h010, 32'h80, 1'b1);
    n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL basic_level_after_push got=%0d exp=2", level); end
    pulse_ev(0);
    n_cmp++; if ({m_psel, m_penable, m_pwrite} !== 3'b101 || m_paddr !== 12'h00C || m_pwdata !== 32'h40) begin
      n_err++; $display("FAIL basic_setup1 psel/pen/pwr=%b addr=%h data=%h exp 101 00c 40", {m_psel, m_penable, m_pwrite}, m_paddr, m_pwdata); end
    @(negedge clk);
    n_cmp++; if ({m_psel, m_penable} !== 2'b11 || m_paddr !== 12'h00C) begin
      n_err++; $display("FAIL basic_access1 psel/pen=%b addr=%h exp 11 00c", {m_psel, m_penable}, m_paddr); end
    @(negedge clk);
    n_cmp++; if ({m_psel, m_penable} !== 2'b10 || m_paddr !== 12'h010 || m_pwdata !== 32'h80) begin
      n_err++; $display("FAIL basic_setup2 psel/pen=%b addr=%h data=%h exp 10 010 80", {m_psel, m_penable}, m_paddr, m_pwdata); end
    wait_idle(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_idle_timeout busy=%b exp=0", busy); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL basic_level_end got=%0d exp=0", level); end
    n_cmp++; if (wr_cnt - base !== 2) begin n_err++; $display("FAIL basic_write_count got=%0d exp=2", wr_cnt - base); end
    n_cmp++; if (log_data[(base + 1) % 64] !== 32'h80 || log_addr[(base + 1) % 64] !== 12'h010) begin
      n_err++; $display("FAIL basic_write2 got=%h/%h exp=010/80", log_addr[(base + 1) % 64], log_data[(base + 1) % 64]); end
  endtask

  task automatic test_underrun_empty();
    int base;
    base = wr_cnt;
    pulse_ev(0);
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL empty_underrun got=%b exp=1", underrun); end
    n_cmp++; if (m_psel !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL empty_no_apb psel=%b busy=%b exp 0 0", m_psel, busy); end
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL empty_underrun_width got=%b exp=0", underrun); end
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_cnt !== base) begin n_err++; $display("FAIL empty_writes got=%0d exp=0", wr_cnt - base); end
  endtask

  task automatic test_gwait();
    bit ok;
    int base;
    base = wr_cnt;
    push(12'h020, 32'h11, 1'b0);
    pulse_ev(0);
    repeat (2) @(negedge clk);
    n_cmp++; if (underrun !== 1'b1 || busy !== 1'b1 || m_psel !== 1'b0) begin
      n_err++; $display("FAIL gwait_entry underrun=%b busy=%b psel=%b exp 1 1 0", underrun, busy, m_psel); end
    push(12'h024, 32'h22, 1'b1);
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL gwait_underrun_once got=%b exp=0", underrun); end
    wait_idle(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL gwait_idle_timeout busy=%b exp=0", busy); end
    n_cmp++; if (wr_cnt - base !== 2 || log_addr[(base + 1) % 64] !== 12'h024 || log_data[(base + 1) % 64] !== 32'h22) begin
      n_err++; $display("FAIL gwait_writes count=%0d addr2=%h data2=%h exp 2 024 22", wr_cnt - base, log_addr[(base + 1) % 64], log_data[(base + 1) % 64]); end
  endtask

  task automatic test_overrun_pending();
    bit ok;
    int base, ov_cnt;
    base = wr_cnt;
    ov_cnt = 0;
    ws = 4;
    push(12'h030, 32'h1, 1'b0);
    push(12'h034, 32'h2, 1'b1);
    push(12'h038, 32'h3, 1'b1);
    pulse_ev(0);
    @(negedge clk);
    pulse_ev(0);
    if (overrun) ov_cnt++;
    @(negedge clk);
    if (overrun) ov_cnt++;
    pulse_ev(0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (overrun) ov_cnt++;
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovr_group1_timeout busy=%b exp=0", busy); end
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL ovr_level_at_idle got=%0d exp=1", level); end
    @(negedge clk);
    n_cmp++; if (m_psel !== 1'b1 || m_paddr !== 12'h038) begin n_err++; $display("FAIL ovr_pending_start psel=%b addr=%h exp 1 038", m_psel, m_paddr); end
    wait_idle(40, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovr_group2_timeout busy=%b exp=0", busy); end
    n_cmp++; if (ov_cnt !== 1) begin n_err++; $display("FAIL ovr_pulse_count got=%0d exp=1", ov_cnt); end
    n_cmp++; if (wr_cnt - base !== 3 || log_data[(base + 2) % 64] !== 32'h3) begin
      n_err++; $display("FAIL ovr_writes count=%0d data3=%h exp 3 3", wr_cnt - base, log_data[(base + 2) % 64]); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_no_extra_group busy=%b exp=0", busy); end
  endtask

  task automatic test_full_flush();
    bit ok;
    int base;
    base = wr_cnt;
    ws = 4;
    for (int i = 0; i < 8; i++) push(12'h040 + 12'(4 * i), 32'(i), 1'b0);
    n_cmp++; if (level !== 4'd8 || push_ready !== 1'b0) begin n_err++; $display("FAIL full_state level=%0d push_ready=%b exp 8 0", level, push_ready); end
    pulse_ev(0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_cmp++; if (push_ready !== 1'b0) begin n_err++; $display("FAIL flush_push_ready got=%b exp=0", push_ready); end
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (level !== 4'd0 || m_penable !== 1'b1) begin n_err++; $display("FAIL flush_mid_access level=%0d penable=%b exp 0 1", level, m_penable); end
    wait_idle(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL flush_idle_timeout busy=%b exp=0", busy); end
    repeat (4) @(negedge clk);
    n_cmp++; if (wr_cnt - base !== 1 || log_addr[base % 64] !== 12'h040) begin
      n_err++; $display("FAIL flush_writes count=%0d addr=%h exp 1 040", wr_cnt - base, log_addr[base % 64]); end
    n_cmp++; if (busy !== 1'b0 || level !== 4'd0 || push_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_end busy=%b level=%0d push_ready=%b exp 0 0 1", busy, level, push_ready); end
    ws = 0;
  endtask

  task automatic test_slverr();
    bit ok;
    int base;
    base = wr_cnt;
    err_at = wr_cnt;
    push(12'h050, 32'h5, 1'b0);
    push(12'h054, 32'h6, 1'b1);
    pulse_ev(0);
    wait_idle(20, ok);
    err_at = -1;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL err_idle_timeout busy=%b exp=0", busy); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", err); end
    n_cmp++; if (wr_cnt - base !== 2) begin n_err++; $display("FAIL err_second_write count=%0d exp=2", wr_cnt - base); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear got=%b exp=0", err); end
  endtask

  task automatic test_en_sel();
    bit ok;
    int base;
    base = wr_cnt;
    en = 1'b0;
    push(12'h070, 32'h9, 1'b1);
    pulse_ev(0);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || level !== 4'd1) begin n_err++; $display("FAIL en_off_ignored busy=%b level=%0d exp 0 1", busy, level); end
    en = 1'b1;
    trig_sel = 2'd2;
    pulse_ev(0);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sel_wrong_bit busy=%b exp=0", busy); end
    pulse_ev(2);
    n_cmp++; if (m_psel !== 1'b1 || m_paddr !== 12'h070) begin n_err++; $display("FAIL sel_bit2_start psel=%b addr=%h exp 1 070", m_psel, m_paddr); end
    wait_idle(20, ok);
    n_cmp++; if (ok !== 1'b1 || wr_cnt - base !== 1) begin n_err++; $display("FAIL sel_bit2_write ok=%b count=%0d exp 1 1", ok, wr_cnt - base); end
    trig_sel = 2'd0;
  endtask

  task automatic test_reset_mid_transfer();
    ws = 4;
    push(12'h060, 32'h7, 1'b1);
    pulse_ev(0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({m_psel, m_penable, m_pwrite} !== 3'b000 || m_paddr !== 12'h0 || m_pwdata !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_apb ctl=%b addr=%h data=%h exp 000 0 0", {m_psel, m_penable, m_pwrite}, m_paddr, m_pwdata); end
    n_cmp++; if (busy !== 1'b0 || level !== 4'd0) begin n_err++; $display("FAIL rst_mid_state busy=%b level=%0d exp 0 0", busy, level); end
    @(negedge clk);
    resetn = 1'b1;
    ws = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_underrun_empty();
    test_gwait();
    test_overrun_pending();
    test_full_flush();
    test_slverr();
    test_en_sel();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
